// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight: IDLE grants and latches, EXEC drives the ALU, RESP holds the result.
module alu_share_arbiter #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic [2:0]           req0_cmd,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  input  logic [2:0]           req1_cmd,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_carryout,
  output logic                 rsp_zero,
  output logic                 rsp_overflow,
  output logic [WIDTH-1:0]     alu_operandA,
  output logic [WIDTH-1:0]     alu_operandB,
  output logic [2:0]           alu_command,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_carryout,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] ops_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_rr_ptr;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2:0]           r_cmd;
  logic                 r_id;
  logic                 r_rsp_valid;
  logic                 r_rsp_id;
  logic [WIDTH-1:0]     r_rsp_result;
  logic                 r_rsp_carryout;
  logic                 r_rsp_zero;
  logic                 r_rsp_overflow;
  logic [CNT_WIDTH-1:0] r_ops_count;

  logic                 w_any_valid;
  logic                 w_grant_id;
  logic                 w_accept;
  logic                 w_rsp_done;

  // A lone requester wins outright; contention is settled by the round-robin pointer.
  assign w_any_valid = req0_valid | req1_valid;
  assign w_grant_id  = (req0_valid & req1_valid) ? r_rr_ptr : req1_valid;
  assign w_accept    = reset_n & (r_state == ST_IDLE) & w_any_valid;
  assign w_rsp_done  = (r_state == ST_RESP) & rsp_ready;

  assign req0_ready = w_accept & ~w_grant_id;
  assign req1_ready = w_accept & w_grant_id;

  assign alu_operandA = r_a;
  assign alu_operandB = r_b;
  assign alu_command  = r_cmd;

  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_result   = r_rsp_result;
  assign rsp_carryout = r_rsp_carryout;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_overflow = r_rsp_overflow;
  assign busy         = (r_state != ST_IDLE);
  assign ops_count    = r_ops_count;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: EXEC always lasts a single cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_state_next = ST_EXEC;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_RESP;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operand latch and round-robin pointer, updated only on a grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_cmd    <= 3'd0;
      r_id     <= 1'b0;
    end else if (w_accept) begin
      r_rr_ptr <= ~w_grant_id;
      r_a      <= w_grant_id ? req1_a   : req0_a;
      r_b      <= w_grant_id ? req1_b   : req0_b;
      r_cmd    <= w_grant_id ? req1_cmd : req0_cmd;
      r_id     <= w_grant_id;
    end
  end

  // Response capture at the end of EXEC; held until the consumer takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_carryout <= 1'b0;
      r_rsp_zero     <= 1'b0;
      r_rsp_overflow <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_rsp_valid    <= 1'b1;
      r_rsp_id       <= r_id;
      r_rsp_result   <= alu_result;
      r_rsp_carryout <= alu_carryout;
      r_rsp_zero     <= alu_zero;
      r_rsp_overflow <= alu_overflow;
    end else if (w_rsp_done) begin
      r_rsp_valid    <= 1'b0;
    end
  end

  // Completed-operation counter, wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ops_count <= '0;
    end else if (w_rsp_done) begin
      r_ops_count <= r_ops_count + CNT_WIDTH'(1);
    end
  end

endmodule
